// File: rtl/riscv_aes_pkg.sv
// Shared types and constants for the AES operand-fetch stage and its writeback unit.
package riscv_aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DONE
  } fetch_state_e;

  localparam int AES_BLOCK_W    = 128;
  localparam int AES_WORD_W     = 32;
  localparam int AES_WORD_BYTES = 4;

  function automatic logic [AES_WORD_W-1:0] bswap32(input logic [AES_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/riscv_aes_fetch.sv
// AES operand fetch: halts the core, reads NUM_WORDS words over req/gnt/rvalid, strobes the block.
// Define AES_FETCH_BSWAP_EN to byte-reverse each received word before storage.
//
// state       | meaning
// ST_IDLE     | waiting for start_i
// ST_REQ      | issuing word requests, address advances on each grant
// ST_WAIT_RSP | all requests granted, collecting remaining responses
// ST_DONE     | block_valid_o strobe cycle, core still halted
module riscv_aes_fetch
  import riscv_aes_pkg::*;
#(
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  output logic                          data_req_o,
  output logic [ADDR_W-1:0]             data_addr_o,
  input  logic                          data_gnt_i,
  input  logic                          data_rvalid_i,
  input  logic [AES_WORD_W-1:0]         data_rdata_i,
  output logic                          halt_en_o,
  output logic [NUM_WORDS*AES_WORD_W-1:0] block_o,
  output logic                          block_valid_o,
  output logic                          busy_o
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int BLK_W = NUM_WORDS * AES_WORD_W;

  fetch_state_e       state_q, state_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic               data_req_q, data_req_d;
  logic [ADDR_W-1:0]  data_addr_q, data_addr_d;
  logic               halt_en_q, halt_en_d;
  logic               busy_q, busy_d;
  logic [BLK_W-1:0]   block_q, block_d;
  logic               block_valid_q, block_valid_d;
  logic               rsp_fire;
  logic [AES_WORD_W-1:0] rsp_word;

`ifdef AES_FETCH_BSWAP_EN
  assign rsp_word = bswap32(data_rdata_i);
`else
  assign rsp_word = data_rdata_i;
`endif

  // A response only counts against a request already granted; stray rvalids are dropped.
  assign rsp_fire = data_rvalid_i && (rsp_cnt_q < req_cnt_q) &&
                    (state_q == ST_REQ || state_q == ST_WAIT_RSP);

  always_comb begin
    state_d       = state_q;
    req_cnt_d     = req_cnt_q;
    rsp_cnt_d     = rsp_cnt_q;
    data_req_d    = data_req_q;
    data_addr_d   = data_addr_q;
    halt_en_d     = halt_en_q;
    busy_d        = busy_q;
    block_d       = block_q;
    block_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          req_cnt_d   = '0;
          rsp_cnt_d   = '0;
          block_d     = '0;
          data_req_d  = 1'b1;
          data_addr_d = {base_addr_i[ADDR_W-1:2], 2'b00};
          halt_en_d   = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (data_gnt_i) begin
          req_cnt_d   = req_cnt_q + 1'b1;
          data_addr_d = data_addr_q + ADDR_W'(AES_WORD_BYTES);
          if (req_cnt_q == CNT_W'(NUM_WORDS - 1)) begin
            data_req_d = 1'b0;
            state_d    = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: ;
      ST_DONE: begin
        halt_en_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rsp_fire) begin
      rsp_cnt_d = rsp_cnt_q + 1'b1;
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (rsp_cnt_q == CNT_W'(i)) block_d[i*AES_WORD_W +: AES_WORD_W] = rsp_word;
      end
    end

    // Looking at the next count lets the strobe land the cycle right after the last rvalid.
    if (state_q == ST_WAIT_RSP && rsp_cnt_d == CNT_W'(NUM_WORDS)) begin
      state_d       = ST_DONE;
      block_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_cnt_q     <= '0;
      rsp_cnt_q     <= '0;
      data_req_q    <= 1'b0;
      data_addr_q   <= '0;
      halt_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      block_q       <= '0;
      block_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_cnt_q     <= req_cnt_d;
      rsp_cnt_q     <= rsp_cnt_d;
      data_req_q    <= data_req_d;
      data_addr_q   <= data_addr_d;
      halt_en_q     <= halt_en_d;
      busy_q        <= busy_d;
      block_q       <= block_d;
      block_valid_q <= block_valid_d;
    end
  end

  assign data_req_o    = data_req_q;
  assign data_addr_o   = data_addr_q;
  assign halt_en_o     = halt_en_q;
  assign busy_o        = busy_q;
  assign block_o       = block_q;
  assign block_valid_o = block_valid_q;

endmodule

// File: tb/tb_riscv_aes_fetch.sv
// Directed bench for riscv_aes_fetch; honours AES_FETCH_BSWAP_EN for expected block contents.
module tb_riscv_aes_fetch;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [31:0]  base_addr_i = '0;
  logic         data_req_o;
  logic [31:0]  data_addr_o;
  logic         data_gnt_i = 1'b0;
  logic         data_rvalid_i = 1'b0;
  logic [31:0]  data_rdata_i = '0;
  logic         halt_en_o;
  logic [127:0] block_o;
  logic         block_valid_o;
  logic         busy_o;

  int total = 0;
  int bad   = 0;

  riscv_aes_fetch #(.NUM_WORDS(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .halt_en_o(halt_en_o),
    .block_o(block_o), .block_valid_o(block_valid_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef AES_FETCH_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   data_req_o, 0);
    chk({tag, "_addr"},  data_addr_o, 0);
    chk({tag, "_halt"},  halt_en_o, 0);
    chk({tag, "_block"}, block_o, 0);
    chk({tag, "_bv"},    block_valid_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
  endtask

  // Drives one fetch with `stall` idle gnt cycles before each grant; memory returns rvalid one
  // cycle after each grant. Cycle numbering: start_i is driven in cycle 0.
  task automatic fetch(input string tag, input logic [31:0] base, input int stall,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3,
                       input bit restart_in_req,
                       output int bv_cycle, output int bv_count, output int last_rv);
    logic [31:0] w [4];
    logic [31:0] exp_base, exp_addr, rv_data;
    logic [127:0] exp_blk;
    bit rv_pend;
    int cyc, n_gnt, stall_cnt;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    exp_blk  = {stored(w3), stored(w2), stored(w1), stored(w0)};
    exp_base = {base[31:2], 2'b00};
    bv_cycle = -1; bv_count = 0; last_rv = -1;
    n_gnt = 0; stall_cnt = 0; rv_pend = 0; rv_data = '0;
    start_i = 1'b1; base_addr_i = base;
    step();
    start_i = 1'b0; base_addr_i = '0;
    cyc = 1;
    for (int k = 0; k < 200; k++) begin
      if (block_valid_o) begin
        bv_count++;
        if (bv_cycle < 0) begin
          bv_cycle = cyc;
          chk({tag, "_block"}, block_o, exp_blk);
        end
      end
      chk({tag, "_halt"}, halt_en_o, (bv_cycle < 0) || (cyc == bv_cycle));
      chk({tag, "_busy"}, busy_o,    (bv_cycle < 0) || (cyc == bv_cycle));
      if (bv_cycle >= 0 && cyc > bv_cycle) break;
      chk({tag, "_req"}, data_req_o, n_gnt < 4);
      data_rvalid_i = rv_pend;
      data_rdata_i  = rv_pend ? rv_data : 32'hBAD0_BAD0;
      if (rv_pend) last_rv = cyc;
      rv_pend = 0;
      data_gnt_i = 1'b0;
      if (n_gnt < 4) begin
        exp_addr = exp_base + 32'(4 * n_gnt);
        chk({tag, "_addr"}, data_addr_o, exp_addr);
        if (stall_cnt == stall) begin
          data_gnt_i = 1'b1;
          rv_pend = 1;
          rv_data = w[n_gnt];
          n_gnt++;
          stall_cnt = 0;
        end else begin
          stall_cnt++;
        end
      end
      start_i = restart_in_req && (cyc == 2);
      base_addr_i = start_i ? 32'h0000_7000 : 32'h0;
      step();
      cyc++;
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; start_i = 1'b0;
    chk({tag, "_timeout"}, bv_cycle >= 0, 1);
    chk({tag, "_bv_after"}, block_valid_o, 0);
    step();
    chk({tag, "_block_hold"}, block_o, exp_blk);
  endtask

  initial begin
    int bvc, bvn, lrv;

    #2;
    chk_all_zero("reset");
    step();
    rst = 1'b0;
    step();
    chk_all_zero("idle");

    // Basic: gnt tied high, strobe at cycle 6, halt 1..6 (checked per cycle in fetch).
    fetch("basic", 32'h0000_1000, 0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
          32'h4444_4444, 0, bvc, bvn, lrv);
    chk("basic_bv_cycle", bvc, 6);
    chk("basic_last_rv", lrv, 5);
    chk("basic_bv_count", bvn, 1);

    // Stalled grants: three idle cycles before each grant.
    fetch("stall", 32'h0000_5000, 3, 32'hA5A5_0001, 32'h5A5A_0002, 32'hCAFE_0003,
          32'hBEEF_0004, 0, bvc, bvn, lrv);
    chk("stall_bv_cycle", bvc, lrv + 1);
    chk("stall_bv_count", bvn, 1);

    // Unaligned base plus a start pulse during REQ which must be ignored.
    fetch("unalign", 32'h0000_2003, 0, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303,
          32'h0404_0404, 1, bvc, bvn, lrv);
    chk("unalign_bv_count", bvn, 1);
    for (int i = 0; i < 4; i++) step();
    chk("unalign_no_refetch_busy", busy_o, 0);
    chk("unalign_no_refetch_req", data_req_o, 0);
    chk("unalign_no_refetch_bv", block_valid_o, 0);

    // Reset after two responses, then stray rvalids in IDLE.
    start_i = 1'b1; base_addr_i = 32'h0000_3000;
    step();
    start_i = 1'b0; base_addr_i = '0;
    data_gnt_i = 1'b1;
    step();
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    step();
    data_rdata_i = 32'h9ABC_DEF0;
    step();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
      step();
      chk("postrst_bv", block_valid_o, 0);
      chk("postrst_busy", busy_o, 0);
      chk("postrst_block", block_o, 0);
    end
    data_rvalid_i = 1'b0;
    step();
    fetch("fresh", 32'h0000_3000, 1, 32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0,
          32'hFEDC_BA98, 0, bvc, bvn, lrv);
    chk("fresh_bv_count", bvn, 1);

    // Address wrap: FFFFFFF8, FFFFFFFC, 0, 4 are checked per grant.
    fetch("wrap", 32'hFFFF_FFF8, 0, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC,
          32'h0000_00DD, 0, bvc, bvn, lrv);
    chk("wrap_bv_count", bvn, 1);

    // Byte order of stored words.
    fetch("bswap", 32'h0000_4000, 0, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C,
          32'h0D0E_0F10, 0, bvc, bvn, lrv);
`ifdef AES_FETCH_BSWAP_EN
    chk("bswap_word0", block_o[31:0], 32'h0403_0201);
`else
    chk("bswap_word0", block_o[31:0], 32'h0102_0304);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_aes_fetch.md
Name: riscv_aes_fetch

Overview:
- Operand-fetch stage directly upstream of the AES core and its writeback unit.
- On a start pulse, halts the core and reads NUM_WORDS consecutive 32-bit words from data memory over the req/gnt/rvalid data port.
- Assembles the words into one AES block and presents it with a single-cycle valid strobe to the AES core.
- The writeback unit later stores the result back using the same word ordering.

Parameters:
- NUM_WORDS, 4, number of 32-bit words fetched per block; the block is NUM_WORDS*32 bits.
- ADDR_W, 32, width of the address bus.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  single-cycle request to fetch a block; sampled only in IDLE.
- base_addr_i  in  ADDR_W  byte address of word 0; sampled with start_i.
- data_req_o  out  1  memory request.
- data_addr_o  out  ADDR_W  memory word address, with bits [1:0] always 0.
- data_gnt_i  in  1  request accepted this cycle.
- data_rvalid_i  in  1  read data valid.
- data_rdata_i  in  32  read data.
- halt_en_o  out  1  stalls the core while a fetch is in progress.
- block_o  out  NUM_WORDS*32  assembled block; word i sits at bits [i*32 +: 32].
- block_valid_o  out  1  one-cycle strobe; block_o is valid and stable.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs go to 0: data_req_o, data_addr_o, halt_en_o, block_o, block_valid_o, busy_o.
  - Request and response counters clear; state becomes IDLE.
  - Reset asserted mid-fetch aborts immediately: data_req_o drops, no block_valid_o is emitted, and late rvalids after reset release are ignored in IDLE.
- States: IDLE, REQ, WAIT_RSP, DONE. All outputs are registered.
- IDLE:
  - On start_i, latch base_addr_i with bits [1:0] forced to 00.
  - Clear the counters and clear block_o.
  - Next cycle: data_req_o=1, data_addr_o=base, halt_en_o=1, busy_o=1; go to REQ.
- REQ:
  - Each cycle with data_gnt_i=1 increments req_cnt and advances data_addr_o by 4.
  - When the final grant occurs (req_cnt==NUM_WORDS-1 with gnt), data_req_o drops next cycle; go to WAIT_RSP.
  - data_req_o and data_addr_o hold stable while gnt is low.
- Responses:
  - Each data_rvalid_i with rsp_cnt<req_cnt+gnt-history writes data_rdata_i into word rsp_cnt, then increments rsp_cnt.
  - rvalid arriving while no request is outstanding is ignored.
  - Responses are accepted in REQ and WAIT_RSP; in-order return is guaranteed by the memory.
- WAIT_RSP: when rsp_cnt reaches NUM_WORDS, go to DONE.
- DONE:
  - block_valid_o=1 for exactly one cycle; halt_en_o stays 1 during this cycle.
  - Next cycle: halt_en_o=0, busy_o=0; return to IDLE.
  - block_o holds its value until the next start_i.
- start_i outside IDLE is ignored and not queued.
- Address arithmetic is modulo 2^ADDR_W; wrap-around past 0xFFFF_FFFC is permitted without error.
- Minimum latency (gnt tied high, rvalid one cycle after gnt), with start_i at cycle 0:
  - req cycles 1–4;
  - rvalid cycles 2–5;
  - block_valid_o cycle 6;
  - halt_en_o high for cycles 1–6.
- rvalid in the same cycle as the last grant for an earlier word must be handled; the response and request counters are independent.

Optional Feature:
- Macro: AES_FETCH_BSWAP_EN.
- Defined: each received word is byte-reversed before storage; data_rdata_i[7:0] lands in word[31:24], and so on.
- Undefined: words are stored unmodified.
- Timing is identical in both cases.

Decomposition:
- Package riscv_aes_pkg holds:
  - the fetch state enum typedef;
  - AES_BLOCK_W=128;
  - AES_WORD_W=32;
  - AES_WORD_BYTES=4.
- The writeback unit is to share the same package.
- Single module; no sub-module is warranted. The counter/assembly logic is small.

Test Plan:
- Basic fetch:
  - Stimulus: start_i with base=0x1000, gnt tied 1, rvalid one cycle later, words 0x11111111..0x44444444.
  - Required: addresses 0x1000/04/08/0C; block_o=0x44444444_33333333_22222222_11111111; block_valid_o at cycle 6; halt_en_o cycles 1–6.
- Stalled grants:
  - Stimulus: gnt low for 3 cycles before each grant.
  - Required: data_addr_o and data_req_o are stable while stalled; the block is correct; block_valid_o fires one cycle after the 4th rvalid.
- Unaligned base and ignored start:
  - Stimulus: base=0x2003; then start_i pulsed during REQ.
  - Required: first address 0x2000; the second start_i is ignored; exactly one block_valid_o.
- Reset mid-fetch:
  - Stimulus: rst asserted after 2 rvalids; rvalid pulsed after release.
  - Required: all outputs 0 and block_valid_o never asserted; a subsequent start_i yields a correct fresh block.
- Wrap-around:
  - Stimulus: base=0xFFFFFFF8.
  - Required: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- AES_FETCH_BSWAP_EN defined:
  - Stimulus: rdata=0x01020304.
  - Required: the stored word is 0x04030201.
